// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, default idle word and counter sizing.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [7:0] TX_IDLE_DEFAULT = 8'hFF;

  // Number of bits needed to hold values 0 .. value-1 (call with WIDTH+1 to count 0..WIDTH).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with single-cycle rise/fall pulses.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_p;
  logic              level_q;

  // Synchroniser chain plus one delayed copy of its output for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p  <= {STAGES{RST_VAL}};
      level_q <= RST_VAL;
    end else begin
      sync_p  <= {sync_p[STAGES-2:0], din};
      level_q <= sync_p[STAGES-1];
    end
  end

  assign rise = sync_p[STAGES-1] & ~level_q;
  assign fall = ~sync_p[STAGES-1] & level_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversampled sclk/cs_n/mosi, MSB-first, back-to-back words per selection.
module spi_responder
  import spi_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                STAGES  = 2,
  parameter logic [DATA_W-1:0] TX_IDLE = DATA_W'(TX_IDLE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              underrun,
  output logic              busy
);

  localparam int             BCW      = clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  logic              sclk_rise, sclk_fall;
  logic              cs_rise, cs_fall;
  logic [STAGES-1:0] mosi_p;
  logic              mosi_s;

  spi_state_e        state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q;
  logic              got_bit_q;
  logic              full_q;
  logic [DATA_W-1:0] txbuf_q;
  logic [DATA_W-1:0] shifter_q;
  logic [DATA_W-2:0] rxshift_q;

  logic              word_start;
  logic              shift_en;
  logic              bit_en;
  logic              word_done;

  sync_edge #(.STAGES(STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge #(.STAGES(STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // mosi needs only the level; it lines up with the sclk edge pulse one flop later.
  always_ff @(posedge clk) begin
    if (rst) mosi_p <= {STAGES{1'b1}};
    else     mosi_p <= {mosi_p[STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_p[STAGES-1];

  // Next state and per-cycle action strobes; cs_n edges outrank sclk edges.
  always_comb begin
    state_d    = state_q;
    word_start = 1'b0;
    shift_en   = 1'b0;
    bit_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          word_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          bit_en = 1'b1;
        end else if (sclk_fall && got_bit_q) begin
          if (bit_cnt_q == '0) word_start = 1'b1;
          else                 shift_en   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_done = bit_en && (bit_cnt_q == LAST_BIT);

  // Control state: FSM, bit counter, buffer occupancy, RX handshake and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      got_bit_q <= 1'b0;
      full_q    <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      overrun  <= 1'b0;
      underrun <= 1'b0;

      if (state_q == IDLE || cs_rise) begin
        bit_cnt_q <= '0;
        got_bit_q <= 1'b0;
      end else if (bit_en) begin
        got_bit_q <= 1'b1;
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
      end

      // A word start only consumes an already-full buffer, so it never races a handshake.
      if (word_start && full_q)       full_q <= 1'b0;
      else if (tx_valid && !full_q)   full_q <= 1'b1;

      if (word_start && !full_q) underrun <= 1'b1;

      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= {rxshift_q, mosi_s};
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Data registers: holding buffer, TX shifter and RX shifter (contents don't matter after reset).
  always_ff @(posedge clk) begin
    if (tx_valid && !full_q) txbuf_q <= tx_data;

    if (word_start)    shifter_q <= full_q ? txbuf_q : TX_IDLE;
    else if (shift_en) shifter_q <= {shifter_q[DATA_W-2:0], 1'b0};

    if (bit_en) rxshift_q <= {rxshift_q[DATA_W-3:0], mosi_s};
  end

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy ? shifter_q[DATA_W-1] : 1'b1;
  assign tx_ready = ~full_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed and randomized bench for spi_responder with a word-level reference model.
module tb_spi_responder;

  localparam int          W         = 8;
  localparam int          SYNC      = 2;
  localparam int          HALF      = 6;
  localparam logic [W-1:0] IDLE_WORD = 8'hFF;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         sclk     = 1'b0;
  logic         cs_n     = 1'b1;
  logic         mosi     = 1'b1;
  logic [W-1:0] tx_data  = '0;
  logic         tx_valid = 1'b0;
  logic         rx_ready = 1'b0;
  logic         miso, miso_oe, tx_ready, rx_valid, overrun, underrun, busy;
  logic [W-1:0] rx_data;

  int checks   = 0;
  int failures = 0;
  int n_under  = 0;
  int n_over   = 0;

  // One selection's worth of words: what the core preloads and what the initiator sends.
  logic [W-1:0] sel_tx   [3];
  logic [W-1:0] sel_mo   [3];
  bit           sel_load [3];
  int           sel_n;

  spi_responder #(.DATA_W(W), .STAGES(SYNC), .TX_IDLE(IDLE_WORD)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    n_under <= n_under + int'(underrun);
    n_over  <= n_over + int'(overrun);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [W-1:0] v);
    chk("tx_ready_before_load", int'(tx_ready), 1);
    tx_data  = v;
    tx_valid = 1'b1;
    ticks(1);
    tx_valid = 1'b0;
    tx_data  = ~v;
    chk("tx_ready_after_load", int'(tx_ready), 0);
  endtask

  task automatic xfer_bit(input logic mo, output logic mi);
    mosi = mo;
    ticks(HALF);
    mi   = miso;
    sclk = 1'b1;
    ticks(HALF);
    sclk = 1'b0;
  endtask

  task automatic xfer_word(input logic [W-1:0] mo, output logic [W-1:0] mi);
    logic b;
    for (int i = W - 1; i >= 0; i--) begin
      xfer_bit(mo[i], b);
      mi[i] = b;
    end
  endtask

  task automatic select_dut();
    cs_n = 1'b0;
    ticks(HALF);
  endtask

  task automatic deselect_dut();
    ticks(HALF);
    cs_n = 1'b1;
    ticks(HALF);
  endtask

  // Words shifted out are the preloaded value or the idle word; every word start without
  // pending data is an underrun, including the start that follows the last word's final fall.
  task automatic run_selection(input string tag);
    int           u0;
    int           o0;
    int           exp_u;
    logic [W-1:0] got;
    logic [W-1:0] exp_mi;
    u0    = n_under;
    o0    = n_over;
    exp_u = 1;
    if (sel_load[0]) load_tx(sel_tx[0]);
    select_dut();
    chk({tag, "_oe"}, int'(miso_oe), 1);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_first_underrun"}, n_under - u0, sel_load[0] ? 0 : 1);
    for (int j = 0; j < sel_n; j++) begin
      if (j + 1 < sel_n && sel_load[j+1]) load_tx(sel_tx[j+1]);
      exp_mi = sel_load[j] ? sel_tx[j] : IDLE_WORD;
      if (!sel_load[j]) exp_u++;
      xfer_word(sel_mo[j], got);
      chk({tag, "_miso"}, int'(got), int'(exp_mi));
      ticks(HALF);
      chk({tag, "_rx_valid"}, int'(rx_valid), 1);
      chk({tag, "_rx_data"}, int'(rx_data), int'(sel_mo[j]));
      ticks(2);
      chk({tag, "_rx_held"}, int'(rx_valid), 1);
      rx_ready = 1'b1;
      ticks(1);
      rx_ready = 1'b0;
      chk({tag, "_rx_cleared"}, int'(rx_valid), 0);
    end
    deselect_dut();
    chk({tag, "_oe_off"}, int'(miso_oe), 0);
    chk({tag, "_underruns"}, n_under - u0, exp_u);
    chk({tag, "_overruns"}, n_over - o0, 0);
  endtask

  initial begin
    logic [W-1:0] got;
    logic         b;
    int           o0;

    // Reset values
    ticks(3);
    chk("rst_miso", int'(miso), 1);
    chk("rst_oe", int'(miso_oe), 0);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    ticks(4);

    // Single word
    sel_n = 1; sel_load[0] = 1'b1; sel_tx[0] = 8'hA5; sel_mo[0] = 8'h3C;
    run_selection("single");

    // Back-to-back words
    sel_n = 2;
    sel_load[0] = 1'b1; sel_tx[0] = 8'h11; sel_mo[0] = 8'hF0;
    sel_load[1] = 1'b1; sel_tx[1] = 8'h22; sel_mo[1] = 8'h0F;
    run_selection("b2b");

    // Underrun
    sel_n = 1; sel_load[0] = 1'b0; sel_mo[0] = W'($urandom);
    run_selection("underrun");

    // Overrun: two words, never accepted in between
    o0 = n_over;
    select_dut();
    xfer_word(8'h01, got);
    ticks(HALF);
    chk("ovr_first_valid", int'(rx_valid), 1);
    chk("ovr_first_data", int'(rx_data), 'h01);
    xfer_word(8'h02, got);
    ticks(HALF);
    chk("ovr_data_kept", int'(rx_data), 'h01);
    chk("ovr_valid_kept", int'(rx_valid), 1);
    chk("ovr_pulses", n_over - o0, 1);
    deselect_dut();
    rx_ready = 1'b1;
    ticks(1);
    rx_ready = 1'b0;
    chk("ovr_cleared", int'(rx_valid), 0);

    // Abort after 5 bits
    o0 = n_over;
    select_dut();
    for (int i = 0; i < 5; i++) xfer_bit(1'($urandom), b);
    cs_n = 1'b1;
    ticks(SYNC + 2);
    chk("abort_oe", int'(miso_oe), 0);
    chk("abort_busy", int'(busy), 0);
    ticks(HALF);
    chk("abort_no_rx", int'(rx_valid), 0);
    chk("abort_no_ovr", n_over - o0, 0);
    sel_n = 1; sel_load[0] = 1'b1; sel_tx[0] = W'($urandom); sel_mo[0] = W'($urandom);
    run_selection("after_abort");

    // Randomized selections
    for (int k = 0; k < 5; k++) begin
      sel_n = int'($urandom_range(1, 3));
      for (int j = 0; j < 3; j++) begin
        sel_load[j] = 1'($urandom);
        sel_tx[j]   = W'($urandom);
        sel_mo[j]   = W'($urandom);
      end
      run_selection("random");
    end

    // Reset mid-word with a pending RX word and a full TX buffer
    select_dut();
    xfer_word(W'($urandom), got);
    ticks(HALF);
    load_tx(W'($urandom));
    for (int i = 0; i < 3; i++) xfer_bit(1'($urandom), b);
    chk("pre_rst_rx_valid", int'(rx_valid), 1);
    rst  = 1'b1;
    cs_n = 1'b1;
    ticks(1);
    chk("midrst_miso", int'(miso), 1);
    chk("midrst_oe", int'(miso_oe), 0);
    chk("midrst_tx_ready", int'(tx_ready), 1);
    chk("midrst_rx_data", int'(rx_data), 0);
    chk("midrst_rx_valid", int'(rx_valid), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_underrun", int'(underrun), 0);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    ticks(HALF);

    sel_n = 2;
    sel_load[0] = 1'b0; sel_mo[0] = W'($urandom);
    sel_load[1] = 1'b1; sel_tx[1] = W'($urandom); sel_mo[1] = W'($urandom);
    run_selection("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
